ps2_scan_rx: RTL and testbench

PS/2 keyboard receiver: oversamples the PS/2 clock/data pins, deframes 11-bit device-to-host frames and buffers validated scancodes in a small FIFO. It sits directly upstream of the keyed lookup mux in the keyboard display path. Its `out_data` scancode is the lookup key that translates scancodes to ASCII and segment patterns. Downstream drains it with a valid/ready handshake.

---
 rtl/ps2_scan_rx.sv | 146 ++++++++++++++
 tb/tb_ps2_scan_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx
// Receives PS/2 device-to-host frames and buffers good scancodes in a FIFO.
// The raw pins are oversampled through 3-flop synchronizers. Each 11-bit
// frame is checked for its start bit, stop bit and odd parity. Good bytes
// are pushed into a power-of-two FIFO, and a valid/ready handshake drains it.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (async, idle high)
//   ps2_data   raw PS/2 data pin (async, idle high)
//   out_valid  FIFO holds at least one scancode
//   out_ready  downstream takes out_data this cycle
//   out_data   oldest buffered scancode
//   overflow   sticky: a good frame was dropped because the FIFO was full
//   frame_err  sticky: start/stop/parity error, or a partial frame timed out
//   err_clr    one-cycle pulse that clears both sticky flags (a new event wins)
module ps2_scan_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       overflow,
    output logic       frame_err,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    s_clk_q, s_dat_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    bits_q, bits_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic [7:0]    mem [FIFO_DEPTH];

    logic fe, bit_in, frame_done, frame_good, frame_bad, timeout;
    logic empty, full, pop, push, drop;

    // The oldest data sample is not needed; s_dat[1] lines up with s_clk[1].
    logic unused_dat;
    assign unused_dat = s_dat_q[2];

    // ---- synchronizer stage: s[0] newest, edge seen between s[2] and s[1]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_clk_q <= 3'b111;
            s_dat_q <= 3'b111;
        end else begin
            s_clk_q <= {s_clk_q[1:0], ps2_clk};
            s_dat_q <= {s_dat_q[1:0], ps2_data};
        end
    end

    always_comb begin
        fe         = s_clk_q[2] & ~s_clk_q[1];
        bit_in     = s_dat_q[1];
        frame_done = fe && (cnt_q == 4'd10);
        // bits_q[0] is the start bit, [8:1] data LSB first, [9] parity;
        // the stop bit is the sample arriving now.
        frame_good = frame_done && !bits_q[0] && bit_in && (^bits_q[9:1]);
        frame_bad  = frame_done && !frame_good;
        timeout    = !fe && (cnt_q != 4'd0) && (idle_q == IW'(TIMEOUT_CYC));

        // ---- deframer / idle timer next state
        cnt_d  = cnt_q;
        bits_d = bits_q;
        idle_d = idle_q;
        if (fe) begin
            idle_d = '0;
            if (cnt_q < 4'd10) begin
                cnt_d  = cnt_q + 4'd1;
                // Shift in from the top so the first bit ends at bits_q[0].
                bits_d = {bit_in, bits_q[9:1]};
            end else begin
                cnt_d = 4'd0;
            end
        end else if (cnt_q != 4'd0) begin
            if (timeout) begin
                cnt_d  = 4'd0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end else begin
            idle_d = '0;
        end

        // ---- FIFO control; the wrap bit tells full apart from empty
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        out_valid = !empty;
        pop       = out_valid && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push      = frame_good && (!full || pop);
        drop      = frame_good && full && !pop;
        wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop  ? rptr_q + PW'(1) : rptr_q;

        // Set has priority over clear.
        ovf_d  = (ovf_q  && !err_clr) || drop;
        ferr_d = (ferr_q && !err_clr) || frame_bad || timeout;
    end

    // ---- control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            idle_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    // ---- data registers: no reset, since cnt and the pointers qualify them
    always_ff @(posedge clk) begin
        bits_q <= bits_d;
        if (push) begin
            mem[wptr_q[AW-1:0]] <= bits_q[8:1];
        end
    end

    assign out_data  = mem[rptr_q[AW-1:0]];
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 200;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, out_ready, err_clr;
    logic       out_valid, overflow, frame_err;
    logic [7:0] out_data;

    int         checks = 0;
    int         errors = 0;
    int         vcount;
    logic [7:0] vdata;
    logic [7:0] q[$];
    logic       m_ovf, m_ferr;
    logic [10:0] fb;

    ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling clock edge and note any visible output.
    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1) begin
            vcount++;
            vdata = out_data;
        end
    endtask

    // Frame layout on the wire: start, 8 data bits LSB first, parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par,
                                       input bit bad_start, input bit bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, bad_start};
    endfunction

    // Drive the first nbits of a frame; optionally pulse out_ready in the
    // cycle in which the stop-bit edge is acted on.
    task automatic send_bits(input logic [10:0] b, input int nbits, input bit pop_at_stop);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = b[i];
            repeat (4) tick();
            ps2_clk = 1'b0;
            tick();
            tick();
            if (pop_at_stop && i == 10) out_ready = 1'b1;
            tick();
            if (pop_at_stop && i == 10) out_ready = 1'b0;
            repeat (5) tick();
            ps2_clk = 1'b1;
            repeat (4) tick();
        end
        ps2_data = 1'b1;
    endtask

    // Reference behaviour of one complete frame with nobody reading.
    task automatic model_frame(input logic [10:0] b);
        if (b[0] == 1'b0 && b[10] == 1'b1 && (^b[9:1]) == 1'b1) begin
            if (q.size() < DEPTH) q.push_back(b[8:1]);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] b);
        send_bits(b, 11, 1'b0);
        model_frame(b);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        while (q.size() > 0) begin
            chk1("drain_valid", out_valid, 1'b1);
            chk8("drain_data", out_data, q.pop_front());
            tick();
        end
        chk1("drain_empty", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic chk_flags(input string tag);
        chk1({tag, "_ovf"}, overflow, m_ovf);
        chk1({tag, "_ferr"}, frame_err, m_ferr);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        out_ready = 1'b0; err_clr = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0; vcount = 0; vdata = 8'h00;
        repeat (3) tick();
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        chk1("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single frame with the reader always ready: one-cycle valid pulse.
        out_ready = 1'b1;
        vcount = 0;
        send_bits(mk(8'h1C, 0, 0, 0), 11, 1'b0);
        out_ready = 1'b0;
        chk8("single_count", 8'(vcount), 8'd1);
        chk8("single_data", vdata, 8'h1C);
        chk_flags("single");

        // Break sequence buffered, then read back-to-back.
        send_frame(mk(8'hF0, 0, 0, 0));
        send_frame(mk(8'h1C, 0, 0, 0));
        chk1("break_valid", out_valid, 1'b1);
        chk8("break_head", out_data, 8'hF0);
        drain();

        // Parity error, clear, then a good frame.
        send_frame(mk(8'h1C, 1, 0, 0));
        chk1("par_valid", out_valid, 1'b0);
        chk_flags("par");
        clear_flags();
        chk_flags("par_clr");
        send_frame(mk(8'h32, 0, 0, 0));
        drain();
        chk_flags("par_after");

        // Overflow: nine frames into an eight-entry buffer.
        for (int i = 1; i <= 9; i++) send_frame(mk(8'(i), 0, 0, 0));
        chk_flags("ovf");
        drain();
        clear_flags();

        // Frame completing in the same cycle as a pop from full.
        for (int i = 0; i < DEPTH; i++) send_frame(mk(8'($urandom), 0, 0, 0));
        fb = mk(8'($urandom), 0, 0, 0);
        send_bits(fb, 11, 1'b1);
        void'(q.pop_front());
        q.push_back(fb[8:1]);
        chk_flags("popfull");
        drain();

        // Timeout of a partial frame.
        send_bits(mk(8'h77, 0, 0, 0), 5, 1'b0);
        repeat (TO - 30) tick();
        chk1("to_early", frame_err, 1'b0);
        repeat (40) tick();
        m_ferr = 1'b1;
        chk_flags("to");
        chk1("to_valid", out_valid, 1'b0);
        clear_flags();
        send_frame(mk(8'h45, 0, 0, 0));
        drain();
        chk_flags("to_after");

        // Reset mid-frame with entries buffered and a flag set.
        for (int i = 0; i < 3; i++) send_frame(mk(8'($urandom), 0, 0, 0));
        send_frame(mk(8'h55, 0, 1, 0));
        send_bits(mk(8'hAA, 0, 0, 0), 6, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("mrst_valid", out_valid, 1'b0);
        chk1("mrst_ferr", frame_err, 1'b0);
        chk1("mrst_ovf", overflow, 1'b0);
        q.delete();
        m_ovf = 1'b0; m_ferr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send_frame(mk(8'h29, 0, 0, 0));
        chk_flags("mrst_after");
        drain();

        // Randomized frames, including corrupted ones.
        for (int i = 0; i < 24; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            send_frame(mk(8'($urandom), r == 0, r == 1, r == 2));
            if (i % 6 == 5) begin
                chk_flags("rnd");
                drain();
                clear_flags();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
